key_matrix_scan: RTL

Debounced 4x4 matrix keypad scanner: the input-side counterpart to the multiplexed 7-segment display driver. It drives keypad rows active-low, samples the pulled-up columns, and debounces presses and releases on a millisecond-scale tick. It reports each accepted press once as an encoded key code.

---
 rtl/key_matrix_scan_pkg.sv | 15 +
 rtl/key_matrix_scan_tick.sv | 18 +
 rtl/key_matrix_scan.sv | 103 ++++++++++
 3 files changed

// File: rtl/key_matrix_scan_pkg.sv
// key_matrix_scan_pkg: shared keypad geometry, FSM encoding and column priority helper
package key_matrix_scan_pkg;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam logic [3:0] COL_IDLE = 4'b1111;
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] DEB_PRESS = 3'd1;
    localparam logic [2:0] SCAN      = 3'd2;
    localparam logic [2:0] HELD      = 3'd3;
    localparam logic [2:0] DEB_REL   = 3'd4;
    // index of the lowest active-low column; the lowest column wins ties
    function automatic logic [1:0] lowest_zero(input logic [3:0] c);
        return !c[0] ? 2'd0 : !c[1] ? 2'd1 : !c[2] ? 2'd2 : 2'd3;
    endfunction
endpackage

// File: rtl/key_matrix_scan_tick.sv
// scan_tick: one-clk tick every TICK_DIV clks, shared with the display scan path
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   tick out  one-cycle pulse every TICK_DIV clks
module scan_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int TW = $clog2(TICK_DIV);
    logic [TW-1:0] r_cnt;
    assign tick = r_cnt == TW'(TICK_DIV - 1);
    always_ff @(posedge clk or negedge rst)
        if (!rst) r_cnt <= '0;
        else      r_cnt <= tick ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/key_matrix_scan.sv
// key_matrix_scan: debounced 4x4 keypad scanner reporting each accepted press once
//   clk       in   system clock
//   rst       in   asynchronous active-low reset
//   col       in   keypad columns, active-low, asynchronous
//   row       out  row drive, active-low
//   key_code  out  row_index*4 + col_index of last accepted key
//   key_valid out  one-clk pulse per accepted press
//   key_down  out  high from acceptance until debounced release
module key_matrix_scan
    import key_matrix_scan_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int DEB_TICKS = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [COLS-1:0] col,
    output logic [ROWS-1:0] row,
    output logic [3:0]      key_code,
    output logic            key_valid,
    output logic            key_down
);
    localparam int CW = $clog2(DEB_TICKS + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_TICKS);
    localparam logic [CW-1:0] ONE     = CW'(1);
    logic          w_tick;
    logic          w_pressed;
    logic [CW-1:0] w_cnt_inc;
    logic [3:0]    r_sync1, r_sync2;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_code;
    logic          r_valid, r_down;

    scan_tick #(.TICK_DIV(TICK_DIV)) u_tick (.clk(clk), .rst(rst), .tick(w_tick));

    assign w_pressed = r_sync2 != COL_IDLE;
    assign w_cnt_inc = (r_cnt == DEB_MAX) ? r_cnt : r_cnt + 1'b1;
    // all rows low while waiting for any key; one row low once scanning or holding
    assign row       = (r_state == IDLE || r_state == DEB_PRESS) ? 4'b0000 : ~(4'b0001 << r_idx);
    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign key_down  = r_down;

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            r_sync1 <= COL_IDLE;
            r_sync2 <= COL_IDLE;
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_down  <= 1'b0;
        end else begin
            r_sync1 <= col;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            if (w_tick)
                case (r_state)
                    IDLE: if (w_pressed) begin
                        r_cnt   <= ONE;
                        r_idx   <= '0;
                        r_state <= (ONE == DEB_MAX) ? SCAN : DEB_PRESS;
                    end
                    DEB_PRESS: if (!w_pressed) r_state <= IDLE;
                    else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == DEB_MAX) begin
                            r_idx   <= '0;
                            r_state <= SCAN;
                        end
                    end
                    // the row was driven for a full tick, so the synchronized columns have settled
                    SCAN: if (w_pressed) begin
                        r_code  <= {r_idx, lowest_zero(r_sync2)};
                        r_down  <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= HELD;
                    end else if (r_idx == 2'd3) r_state <= IDLE;
                    else r_idx <= r_idx + 1'b1;
                    HELD: if (!w_pressed) begin
                        r_cnt <= ONE;
                        if (ONE == DEB_MAX) begin
                            r_down  <= 1'b0;
                            r_state <= IDLE;
                        end else r_state <= DEB_REL;
                    end
                    DEB_REL: if (w_pressed) begin
                        r_cnt   <= '0;
                        r_state <= HELD;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_inc == DEB_MAX) begin
                            r_down  <= 1'b0;
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
        end
endmodule
